// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch refill logic: refill FSM state encoding,
// default line geometry and a width helper.
package fetch_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t FETCH  = 3'd1;
  localparam state_t COMMIT = 3'd2;
  localparam state_t DONE   = 3'd3;
  localparam state_t ERR    = 3'd4;

  localparam int unsigned DEF_LINE_WORDS = 4;
  localparam int unsigned DEF_TIMEOUT    = 64;

  // Counter width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/refill_watchdog.sv
// Stall watchdog for a line refill: counts enabled cycles since the last clear and flags
// expiry on the cycle the count reaches TIMEOUT-1 without a clear.
module refill_watchdog
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned WD_W = clog2_min1(TIMEOUT);

  logic [WD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + WD_W'(1);
    end
  end

  // A clear in the same cycle (word returned) takes priority over expiry.
  assign expire = enable && !clear && (cnt_q == WD_W'(TIMEOUT - 1));

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache line refill sequencer: on a fetch miss it stalls fetch, reads one line word by
// word over a req/ack memory port, writes it into the data array and validates the tag.
module icache_refill_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Imiss,
  input  logic [ADDR_W-1:0] MissAddr,
  input  logic              FlushPipeandPC,
  output logic              RefillStall,
  output logic              MemReq,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic              MemAck,
  input  logic [DATA_W-1:0] MemRData,
  output logic              CacheWE,
  output logic [ADDR_W-1:0] CacheWAddr,
  output logic [DATA_W-1:0] CacheWData,
  output logic              CacheValidate,
  output logic [ADDR_W-1:0] CacheTagAddr,
  output logic              RefillDone,
  output logic              RefillErr
);

  localparam int unsigned LINE_BYTES = LINE_WORDS * 4;
  localparam int unsigned OFFS_W     = clog2_min1(LINE_BYTES);
  localparam int unsigned CNT_W      = clog2_min1(LINE_WORDS);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              in_fetch, ack, wd_clear, wd_expire;
  logic [ADDR_W-1:0] word_addr;

  assign in_fetch  = (state_q == FETCH);
  assign ack       = in_fetch && MemAck;
  assign wd_clear  = !in_fetch || MemAck;
  assign word_addr = base_q + (ADDR_W'(cnt_q) << 2);

  refill_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .Clk   (Clk),
    .Rst   (Rst),
    .clear (wd_clear),
    .enable(in_fetch),
    .expire(wd_expire)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // A miss raised together with a redirect is on the wrong path.
        if (Imiss && !FlushPipeandPC) begin
          base_d  = (MissAddr >> OFFS_W) << OFFS_W;
          cnt_d   = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (MemAck) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(LINE_WORDS - 1)) begin
            state_d = COMMIT;
          end
        end else if (wd_expire) begin
          state_d = ERR;
        end
      end
      COMMIT:  state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      we_q    <= ack;
      waddr_q <= ack ? word_addr : '0;
      wdata_q <= ack ? MemRData : '0;
    end
  end

  assign RefillStall   = in_fetch || (state_q == COMMIT);
  assign MemReq        = in_fetch;
  assign MemAddr       = in_fetch ? word_addr : '0;
  assign CacheWE       = we_q;
  assign CacheWAddr    = waddr_q;
  assign CacheWData    = wdata_q;
  assign CacheValidate = (state_q == COMMIT);
  assign CacheTagAddr  = (state_q == COMMIT) ? base_q : '0;
  assign RefillDone    = (state_q == DONE);
  assign RefillErr     = (state_q == ERR);

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: directed and randomized refills compared cycle by cycle
// against a transaction-level timeline model.
module tb_icache_refill_ctrl;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 4;
  localparam int unsigned TO = 64;

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          Imiss = 1'b0;
  logic [AW-1:0] MissAddr = '0;
  logic          FlushPipeandPC = 1'b0;
  logic          MemAck = 1'b0;
  logic [DW-1:0] MemRData = '0;
  logic          RefillStall, MemReq, CacheWE, CacheValidate, RefillDone, RefillErr;
  logic [AW-1:0] MemAddr, CacheWAddr, CacheTagAddr;
  logic [DW-1:0] CacheWData;

  icache_refill_ctrl #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .LINE_WORDS(LW),
    .TIMEOUT   (TO)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .Imiss         (Imiss),
    .MissAddr      (MissAddr),
    .FlushPipeandPC(FlushPipeandPC),
    .RefillStall   (RefillStall),
    .MemReq        (MemReq),
    .MemAddr       (MemAddr),
    .MemAck        (MemAck),
    .MemRData      (MemRData),
    .CacheWE       (CacheWE),
    .CacheWAddr    (CacheWAddr),
    .CacheWData    (CacheWData),
    .CacheValidate (CacheValidate),
    .CacheTagAddr  (CacheTagAddr),
    .RefillDone    (RefillDone),
    .RefillErr     (RefillErr)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic          stall;
    logic          req;
    logic [AW-1:0] maddr;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          val;
    logic [AW-1:0] tag;
    logic          done;
    logic          err;
  } out_t;

  out_t obs;
  assign obs = {RefillStall, MemReq, MemAddr, CacheWE, CacheWAddr, CacheWData,
                CacheValidate, CacheTagAddr, RefillDone, RefillErr};

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;

  // Transaction plan: cycle indices are counted from the first cycle spent refilling.
  logic [AW-1:0] base;
  logic [DW-1:0] dat[LW];
  int            gaps[LW];
  int            ack_t[LW];
  int            n_ok, err_t, rst_t, flush_t, fetch_end, term_t, last_t;
  bit            has_err;
  bit            fixed_data = 1'b0;

  task automatic plan(input logic [AW-1:0] addr, input int rst_at);
    int prev;
    prev    = -1;
    base    = addr & ~AW'(LW * 4 - 1);
    has_err = 1'b0;
    n_ok    = LW;
    err_t   = -1;
    rst_t   = rst_at;
    for (int j = 0; j < LW; j++) begin
      dat[j]   = fixed_data ? DW'(32'hA0 + j) : DW'($urandom);
      ack_t[j] = 0;
      if (!has_err) begin
        if (gaps[j] >= int'(TO)) begin
          has_err = 1'b1;
          err_t   = prev + 1 + int'(TO);
          n_ok    = j;
        end else begin
          ack_t[j] = prev + 1 + gaps[j];
          prev     = ack_t[j];
        end
      end
    end
    fetch_end = has_err ? err_t - 1 : ack_t[LW-1];
    term_t    = has_err ? err_t : fetch_end + 2;
    last_t    = (rst_t >= 0) ? rst_t + 2 : term_t + 1;
    flush_t   = (n_ok >= 2) ? ack_t[1] + 1 : -1;
  endtask

  function automatic out_t expect_at(input int t);
    out_t e;
    int   k;
    e = '0;
    k = 0;
    if (rst_t >= 0 && t > rst_t) return e;
    for (int j = 0; j < n_ok; j++) if (ack_t[j] < t) k++;
    if (t <= fetch_end) begin
      e.stall = 1'b1;
      e.req   = 1'b1;
      e.maddr = base + AW'(4 * k);
    end
    for (int j = 0; j < n_ok; j++) begin
      if (ack_t[j] + 1 == t) begin
        e.we    = 1'b1;
        e.waddr = base + AW'(4 * j);
        e.wdata = dat[j];
      end
    end
    if (has_err) begin
      e.err = (t == err_t);
    end else begin
      if (t == fetch_end + 1) begin
        e.stall = 1'b1;
        e.val   = 1'b1;
        e.tag   = base;
      end
      e.done = (t == fetch_end + 2);
    end
    return e;
  endfunction

  task automatic check(input string tag, input out_t exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, required %h", tag, obs, exp);
    end
  endtask

  task automatic run_refill(input string name, input logic [AW-1:0] addr, input int rst_at);
    plan(addr, rst_at);
    @(negedge Clk);
    check({name, " idle-before"}, '0);
    Imiss          = 1'b1;
    MissAddr       = addr;
    FlushPipeandPC = 1'b0;
    MemAck         = 1'($urandom_range(0, 1));
    MemRData       = DW'($urandom);
    for (int t = 0; t <= last_t; t++) begin
      bit ack_now;
      int aj;
      @(negedge Clk);
      check($sformatf("%s t=%0d", name, t), expect_at(t));
      ack_now = 1'b0;
      aj      = 0;
      for (int j = 0; j < n_ok; j++) begin
        if (ack_t[j] == t) begin
          ack_now = 1'b1;
          aj      = j;
        end
      end
      // Stray acks are only offered once the line no longer expects data.
      MemAck         = ack_now ? 1'b1 : ((t > fetch_end) ? 1'($urandom_range(0, 1)) : 1'b0);
      MemRData       = ack_now ? dat[aj] : DW'($urandom);
      Imiss          = (t <= term_t) && (rst_t < 0 || t < rst_t);
      FlushPipeandPC = (t == flush_t) || ($urandom_range(0, 3) == 0);
      if (t == rst_t) Rst = 1'b0;
    end
    Rst            = 1'b1;
    Imiss          = 1'b0;
    FlushPipeandPC = 1'b0;
    MemAck         = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    check("reset", '0);
    Rst = 1'b1;

    fixed_data = 1'b1;
    gaps = '{0, 0, 0, 0};
    run_refill("basic", 32'h0000_1034, -1);
    fixed_data = 1'b0;

    gaps = '{3, 3, 3, 3};
    run_refill("slow", 32'h0000_4ABC, -1);

    @(negedge Clk);
    Imiss          = 1'b1;
    MissAddr       = 32'h0000_3000;
    FlushPipeandPC = 1'b1;
    @(negedge Clk);
    check("wrong-path", '0);
    Imiss          = 1'b0;
    FlushPipeandPC = 1'b0;
    @(negedge Clk);
    check("wrong-path-after", '0);

    gaps = '{0, int'(TO) - 1, 0, 0};
    run_refill("wd-edge", 32'h0000_8010, -1);

    gaps = '{int'(TO), 0, 0, 0};
    run_refill("timeout", 32'h0000_9000, -1);

    gaps = '{0, 0, int'(TO), 0};
    run_refill("timeout-mid", 32'h0000_9124, -1);

    gaps = '{0, 0, 0, 0};
    run_refill("rst-mid", 32'h0000_5008, 2);
    run_refill("after-rst", 32'h0000_2000, -1);

    gaps = '{1, 0, 2, 0};
    run_refill("top-of-mem", 32'hFFFF_FFFC, -1);

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < LW; j++) gaps[j] = $urandom_range(0, 3);
      run_refill($sformatf("rand%0d", i), AW'($urandom), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
- Sequences instruction-cache line refills for the fetch stage. On an instruction miss it freezes PC and IF/ID, reads one cache line word by word from main memory over a req/ack port, and writes each word into the I-cache. It then validates the line's tag and releases fetch to retry.
- Sits between the fetch logic (Imiss, InstrAddr), the hazard unit (stall) and the memory interface.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, word width
- LINE_WORDS, 4, words per line (power of 2, >=2)
- TIMEOUT, 64, max cycles waiting for MemAck per word before error

Ports:
- Clk  in  1  clock
- Rst  in  1  reset, synchronous, active-low
- Imiss  in  1  fetch miss indication
- MissAddr  in  ADDR_W  InstrAddr of missing fetch
- FlushPipeandPC  in  1  hazard-unit redirect
- RefillStall  out  1  to hazard unit: hold PC and IF/ID
- MemReq  out  1  memory read request
- MemAddr  out  ADDR_W  word address of request
- MemAck  in  1  word returned this cycle
- MemRData  in  DATA_W  returned data, valid with MemAck
- CacheWE  out  1  I-cache data write strobe
- CacheWAddr  out  ADDR_W  data write address
- CacheWData  out  DATA_W  data write value
- CacheValidate  out  1  tag write / valid-bit set strobe
- CacheTagAddr  out  ADDR_W  line base for tag write
- RefillDone  out  1  one-cycle pulse, line committed
- RefillErr  out  1  one-cycle pulse, timeout abort

Behaviour:
- Reset (Rst=0 at edge): state IDLE. All outputs 0, word count 0, watchdog 0. Applies mid-refill: MemReq drops the next edge and the line is never validated.
- Line base: MissAddr with the low log2(LINE_WORDS*4) bits cleared, latched on entry to FETCH.
- IDLE:
  - Outputs idle.
  - Imiss=1 and FlushPipeandPC=0: latch base, count=0, go to FETCH.
  - Imiss together with FlushPipeandPC is ignored (wrong-path miss).
- FETCH:
  - RefillStall=1, MemReq=1, MemAddr=base+count*4. MemReq is held high across words.
  - Each cycle with MemAck=1 transfers one word.
  - Next cycle: CacheWE=1, CacheWAddr=that word's address, CacheWData=captured MemRData. Registered, so latency is 1 cycle.
  - On ack: count increments and the watchdog clears.
  - Ack with count==LINE_WORDS-1: go to COMMIT. MemReq is 0 from COMMIT onward.
  - MemAck outside FETCH is ignored.
- COMMIT (1 cycle):
  - RefillStall=1.
  - CacheWE writes the last word.
  - CacheValidate=1, CacheTagAddr=base.
  - Go to DONE.
- DONE (1 cycle):
  - RefillStall=0, RefillDone=1.
  - Imiss is ignored this cycle because fetch is retrying.
  - Go to IDLE.
- Watchdog:
  - Counts FETCH cycles without ack.
  - Reaching TIMEOUT-1 with no ack: go to ERR.
- ERR (1 cycle):
  - RefillErr=1, RefillStall=0, no validate.
  - Go to IDLE.
  - Words already written stay in the data array but the line is not valid.
- FlushPipeandPC during FETCH/COMMIT does not abort. The line completes and is validated, since its data is correct regardless of path, and the stall holds until DONE.
- Address arithmetic is ADDR_W-bit unsigned. A base near the top of the address space wraps modulo 2^ADDR_W; there is no special handling.
- No refill pipelining: only one line is outstanding.

Decomposition:
- fetch_pkg holds:
  - state enum {IDLE, FETCH, COMMIT, DONE, ERR}
  - localparams LINE_BYTES, OFFS_W=log2(LINE_BYTES), CNT_W=log2(LINE_WORDS), WD_W=log2(TIMEOUT)
- One sub-module, refill_watchdog: clear/enable/expire counter, parameterised by TIMEOUT.

Test Plan:
- Basic refill: Imiss=1, MissAddr=0x0000_1034, MemAck every cycle with data 0xA0..A3 -> MemAddr 0x1030, 0x1034, 0x1038, 0x103C. CacheWE writes those addresses one cycle after each ack. CacheValidate with CacheTagAddr=0x1030. RefillDone 6 cycles after entry. RefillStall high for 5 cycles.
- Slow memory: acks with 3 idle cycles between words -> MemAddr is held constant between acks, CacheWE count is exactly 4, no RefillErr.
- Wrong-path miss: Imiss=1 and FlushPipeandPC=1 in the same cycle -> stays IDLE, MemReq=0, RefillStall=0.
- Flush mid-refill: FlushPipeandPC pulse after the 2nd ack -> all 4 words are still written, CacheValidate=1, RefillDone=1.
- Timeout: no MemAck after entry -> RefillErr pulse after TIMEOUT cycles in FETCH, CacheValidate never asserted, back to IDLE with RefillStall=0.
- Reset mid-refill: Rst=0 after the 2nd ack -> next edge all outputs 0 and state IDLE. After Rst=1, a new miss at 0x2000 starts cleanly at MemAddr=0x2000.
